// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller over a simple dual-port RAM with a 2-entry output skid buffer; push-to-out_valid latency 3 cycles.
// Backpressure: in_ready drops only when the RAM is full; the skid buffer holds its head while out_ready is low.
module dpram_fifo_ctrl #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [DATA_W-1:0]   rd_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [ADDR_W+1:0]   count,
    output logic                almost_full
);
    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [ADDR_W+1:0] AFULL_W  = (ADDR_W+2)'(AFULL_THRESH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   mem_cnt;
    logic              rd_pending;
    logic [1:0]        obuf_cnt;
    logic [DATA_W-1:0] ob_head;
    logic [DATA_W-1:0] ob_tail;
    logic              push;
    logic              pop;
    logic [2:0]        obuf_next;

    assign in_ready  = !rst && (mem_cnt < DEPTH_W);
    assign push      = in_valid && in_ready;
    assign wr_en     = push;
    assign wr_addr   = wr_ptr;
    assign wr_data   = in_data;

    assign out_valid = (obuf_cnt != 2'd0);
    assign out_data  = ob_head;
    assign pop       = out_valid && out_ready;

    // Occupancy the skid buffer will have next cycle; a new read may only launch if a slot remains.
    assign obuf_next = {1'b0, obuf_cnt} + {2'b00, rd_pending} - {2'b00, pop};
    assign rd_en     = (mem_cnt != '0) && (obuf_next < 3'd2);
    assign rd_addr   = rd_ptr;

    assign count       = {1'b0, mem_cnt} + (ADDR_W+2)'(rd_pending) + (ADDR_W+2)'(obuf_cnt);
    assign almost_full = (count >= AFULL_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_cnt    <= '0;
            rd_pending <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !rd_en) begin
                mem_cnt <= mem_cnt + 1'b1;
            end else if (!push && rd_en) begin
                mem_cnt <= mem_cnt - 1'b1;
            end
            rd_pending <= rd_en;
        end
    end

    // Skid buffer: RAM read data lands at the tail the cycle after rd_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            obuf_cnt <= 2'd0;
            ob_head  <= '0;
            ob_tail  <= '0;
        end else begin
            if (rd_pending && pop) begin
                if (obuf_cnt == 2'd2) begin
                    ob_head <= ob_tail;
                    ob_tail <= rd_data;
                end else begin
                    ob_head <= rd_data;
                end
            end else if (pop) begin
                ob_head  <= ob_tail;
                obuf_cnt <= obuf_cnt - 2'd1;
            end else if (rd_pending) begin
                if (obuf_cnt == 2'd0) begin
                    ob_head <= rd_data;
                end else begin
                    ob_tail <= rd_data;
                end
                obuf_cnt <= obuf_cnt + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl with a behavioural simple dual-port RAM attached.
module tb_dpram_fifo_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [5:0] count;
    logic       almost_full;

    int checks   = 0;
    int failures = 0;

    logic [7:0] ram [16];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en) ram[wr_addr] <= wr_data;
        if (rd_en) rd_data <= ram[rd_addr];
    end

    dpram_fifo_ctrl #(.DATA_W(8), .ADDR_W(4), .AFULL_THRESH(12)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .almost_full(almost_full)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after a rising edge, return at the following falling edge for sampling.
    task automatic drive(input logic iv, input logic [7:0] id, input logic ordy);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_d;
        logic [7:0] prev_d;
        logic       prev_hold;
        int         acc;
        int         got;
        int         sent;

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_count", count, 0);
        chk("rst_afull", almost_full, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);

        // Single word latency
        drive(1'b1, 8'hA5, 1'b0);
        chk("t1_c0_wr_en", wr_en, 1);
        chk("t1_c0_wr_addr", wr_addr, 0);
        chk("t1_c0_count", count, 0);
        drive(1'b0, 8'h00, 1'b0);
        chk("t1_c1_rd_en", rd_en, 1);
        chk("t1_c1_count", count, 1);
        drive(1'b0, 8'h00, 1'b0);
        chk("t1_c2_out_valid", out_valid, 0);
        chk("t1_c2_count", count, 1);
        drive(1'b0, 8'h00, 1'b1);
        chk("t1_c3_out_valid", out_valid, 1);
        chk("t1_c3_out_data", out_data, 8'hA5);
        chk("t1_c3_count", count, 1);
        drive(1'b0, 8'h00, 1'b0);
        chk("t1_c4_count", count, 0);
        chk("t1_c4_out_valid", out_valid, 0);

        // Fill with the consumer stalled
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            chk("t2_count", count, acc);
            chk("t2_in_ready", in_ready, (acc < 18) ? 1 : 0);
            chk("t2_afull", almost_full, (acc >= 12) ? 1 : 0);
            if (i >= 4) chk("t2_head_held", out_data, 8'h00);
            if (in_ready) acc++;
        end
        chk("t2_accepted", acc, 18);
        drive(1'b0, 8'h00, 1'b0);
        chk("t2_full_count", count, 18);
        chk("t2_full_out_data", out_data, 8'h00);

        // Full plus single-cycle drain
        drive(1'b0, 8'h00, 1'b1);
        chk("t5_pop_valid", out_valid, 1);
        chk("t5_pop_data", out_data, 8'h00);
        chk("t5_pop_in_ready", in_ready, 0);
        chk("t5_pop_rd_en", rd_en, 1);
        drive(1'b0, 8'h00, 1'b0);
        chk("t5_in_ready_next", in_ready, 1);
        chk("t5_count_next", count, 17);
        drive(1'b1, 8'hEE, 1'b0);
        chk("t5_push_wr_en", wr_en, 1);
        q.delete();
        for (int k = 1; k <= 17; k++) q.push_back(8'(k));
        q.push_back(8'hEE);
        got = 0;
        for (int c = 0; c < 60 && got < 18; c++) begin
            drive(1'b0, 8'h00, 1'b1);
            if (out_valid) begin
                exp_d = q.pop_front();
                chk("t5_drain_data", out_data, exp_d);
                got++;
            end
        end
        chk("t5_drained", got, 18);
        drive(1'b0, 8'h00, 1'b0);
        chk("t5_empty_count", count, 0);

        // Continuous streaming
        for (int c = 0; c < 106; c++) begin
            drive(c < 100, 8'(c), 1'b1);
            if (c < 100) chk("t3_in_ready", in_ready, 1);
            chk("t3_out_valid", out_valid, (c >= 3 && c <= 102) ? 1 : 0);
            if (c >= 3 && c <= 102) chk("t3_out_data", out_data, c - 3);
            chk("t3_count_le3", (count <= 6'd3), 1);
        end

        // Random backpressure across pointer wraps
        q.delete();
        sent = 0; got = 0; prev_hold = 1'b0; prev_d = 8'h00;
        for (int c = 0; c < 400 && got < 40; c++) begin
            drive(sent < 40, 8'(8'h40 + sent), 1'($urandom_range(0, 1)));
            if (prev_hold) begin
                chk("t4_hold_valid", out_valid, 1);
                chk("t4_hold_data", out_data, prev_d);
            end
            if (in_valid && in_ready) begin
                q.push_back(in_data);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("t4_spurious_pop", 1, 0);
                end else begin
                    exp_d = q.pop_front();
                    chk("t4_order", out_data, exp_d);
                end
                got++;
            end
            prev_hold = out_valid && !out_ready;
            prev_d    = out_data;
        end
        chk("t4_received", got, 40);

        // Reset in the middle of a stream
        for (int i = 0; i < 7; i++) drive(1'b1, 8'(8'h70 + i), 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        chk("t6_pre_count", count, 7);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_count", count, 0);
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_in_ready", in_ready, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        drive(1'b1, 8'h3C, 1'b0);
        chk("t6_c0_wr_en", wr_en, 1);
        drive(1'b0, 8'h00, 1'b0);
        chk("t6_c1_rd_en", rd_en, 1);
        drive(1'b0, 8'h00, 1'b0);
        chk("t6_c2_out_valid", out_valid, 0);
        drive(1'b0, 8'h00, 1'b1);
        chk("t6_c3_out_valid", out_valid, 1);
        chk("t6_c3_out_data", out_data, 8'h3C);
        drive(1'b0, 8'h00, 1'b1);
        chk("t6_c4_out_valid", out_valid, 0);
        chk("t6_c4_count", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
